// File: rtl/bp_pkg.sv
// Shared branch-prediction types: predictor state encoding, PC step and the
// in-flight prediction entry carried from fetch to execute.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_e;

  localparam int unsigned BP_AW  = 32;
  localparam int unsigned PC_INC = 4;

  // Fields are BP_AW wide; narrower address builds zero-extend into them.
  typedef struct packed {
    logic             taken;
    logic [BP_AW-1:0] pc;
    logic [BP_AW-1:0] target;
  } bp_entry_t;

endpackage

// File: rtl/bp_fifo.sv
// In-order prediction queue: DEPTH entries, wrap-around pointers, separate
// occupancy counter and a single-cycle flush that wins over a same-cycle push.
module bp_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  bp_entry_t                wdata_i,
  output bp_entry_t                rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  bp_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign full_o      = (occ_q == OW'(DEPTH));
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: checks queued predictions against the ALU
// outcome, feeds the predictor update, redirects fetch and keeps statistics.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int CW    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic                   pred_taken,
  input  logic [AW-1:0]          pred_pc,
  input  logic [AW-1:0]          pred_target,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [AW-1:0]          res_target,
  output logic                   upd_valid,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [AW-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CW-1:0]          branch_count,
  output logic [CW-1:0]          mispredict_count,
  output logic                   underflow_err
);

  bp_entry_t     wr_entry, head;
  logic          full, empty;
  logic          push, res_fire, mis_det;
  logic [AW-1:0] head_pc, head_target, redirect_d;

  logic          upd_valid_q, upd_taken_q, mispredict_q, underflow_q;
  logic          underflow_d;
  logic [AW-1:0] redirect_q;
  logic [CW-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  always_comb begin
    wr_entry            = '0;
    wr_entry.taken      = pred_taken;
    wr_entry.pc[AW-1:0] = pred_pc;
    wr_entry.target[AW-1:0] = pred_target;
  end

  // Ready depends only on registered state, never on res_valid.
  assign pred_ready  = !full && !mispredict_q;
  assign push        = pred_valid && pred_ready;
  assign res_fire    = res_valid && !empty;
  assign head_pc     = head.pc[AW-1:0];
  assign head_target = head.target[AW-1:0];

  assign mis_det = res_fire &&
                   ((head.taken != res_taken) ||
                    (head.taken && res_taken && (head_target != res_target)));

  assign redirect_d = res_taken ? res_target : head_pc + AW'(PC_INC);

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (res_fire),
    .flush_i     (mis_det),
    .wdata_i     (wr_entry),
    .rdata_o     (head),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occupancy)
  );

  always_comb begin
    bcnt_d      = bcnt_q;
    mcnt_d      = mcnt_q;
    underflow_d = underflow_q || (res_valid && empty);
    if (res_fire && (bcnt_q != '1)) bcnt_d = bcnt_q + CW'(1);
    if (mis_det  && (mcnt_q != '1)) mcnt_d = mcnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      upd_valid_q  <= 1'b0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      bcnt_q       <= '0;
      mcnt_q       <= '0;
      underflow_q  <= 1'b0;
    end else begin
      upd_valid_q  <= res_fire;
      upd_taken_q  <= res_fire && res_taken;
      mispredict_q <= mis_det;
      redirect_q   <= mis_det ? redirect_d : '0;
      bcnt_q       <= bcnt_d;
      mcnt_q       <= mcnt_d;
      underflow_q  <= underflow_d;
    end
  end

  assign upd_valid        = upd_valid_q;
  assign upd_taken        = upd_taken_q;
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;
  assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          pred_valid, pred_taken;
  logic [AW-1:0] pred_pc, pred_target;
  logic          res_valid, res_taken;
  logic [AW-1:0] res_target;
  logic          pred_ready, upd_valid, upd_taken, mispredict, underflow_err;
  logic [AW-1:0] redirect_pc;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CW-1:0] branch_count, mispredict_count;

  always #5 clock = ~clock;

  branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .occupancy(occupancy),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .underflow_err(underflow_err)
  );

  typedef struct {
    logic          taken;
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
  } pred_t;

  pred_t         mq[$];
  logic          e_upd, e_upd_t, e_mis, e_uf;
  logic [AW-1:0] e_redir;
  int            e_bc, e_mc;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    e_upd = 0; e_upd_t = 0; e_mis = 0; e_uf = 0; e_redir = '0; e_bc = 0; e_mc = 0;
  endtask

  // Reference: what the edge about to happen should do, from the spec rules.
  task automatic model_step();
    pred_t h;
    logic  rdy, do_push, wrong;
    if (reset) begin
      model_reset();
      return;
    end
    rdy     = (mq.size() < DEPTH) && !e_mis;
    do_push = pred_valid && rdy;
    e_upd = 0; e_upd_t = 0; e_mis = 0;
    if (res_valid) begin
      if (mq.size() == 0) e_uf = 1;
      else begin
        h = mq.pop_front();
        e_upd = 1;
        e_upd_t = res_taken;
        e_bc = (e_bc < CMAX) ? e_bc + 1 : CMAX;
        wrong = (h.taken != res_taken) || (h.taken && res_taken && h.target != res_target);
        if (wrong) begin
          e_mis = 1;
          e_redir = res_taken ? res_target : h.pc + 32'd4;
          e_mc = (e_mc < CMAX) ? e_mc + 1 : CMAX;
          mq.delete();
          do_push = 0;
        end
      end
    end
    if (do_push) mq.push_back('{taken: pred_taken, pc: pred_pc, target: pred_target});
  endtask

  task automatic cycle();
    @(negedge clock);
    check("pred_ready", pred_ready, (mq.size() < DEPTH) && !e_mis);
    check("occupancy", occupancy, mq.size());
    check("upd_valid", upd_valid, e_upd);
    if (e_upd) check("upd_taken", upd_taken, e_upd_t);
    check("mispredict", mispredict, e_mis);
    if (e_mis) check("redirect_pc", redirect_pc, e_redir);
    check("branch_count", branch_count, e_bc);
    check("mispredict_count", mispredict_count, e_mc);
    check("underflow_err", underflow_err, e_uf);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [AW-1:0] ppc,
                       input logic [AW-1:0] ptg, input logic rv, input logic rt,
                       input logic [AW-1:0] rtg);
    pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    cycle();
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    pred_valid = 0; pred_taken = 0; pred_pc = '0; pred_target = '0;
    res_valid = 0; res_taken = 0; res_target = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    model_reset();
    reset = 0;
    check("rst_ready", pred_ready, 1);
    check("rst_occ", occupancy, 0);

    // correct not-taken prediction
    drive(1, 0, 32'h100, 32'h0, 0, 0, '0);
    drive(0, 0, '0, '0, 1, 0, '0);
    check("t1_upd_valid", upd_valid, 1);
    check("t1_upd_taken", upd_taken, 0);
    check("t1_mis", mispredict, 0);
    check("t1_bc", branch_count, 1);
    check("t1_occ", occupancy, 0);

    // direction mispredict
    drive(1, 0, 32'h200, 32'h0, 0, 0, '0);
    drive(0, 0, '0, '0, 1, 1, 32'h400);
    check("t2_mis", mispredict, 1);
    check("t2_redir", redirect_pc, 32'h400);
    check("t2_mc", mispredict_count, 1);
    idle();

    // target mispredict, then not-taken fall-through
    drive(1, 1, 32'h300, 32'h500, 0, 0, '0);
    drive(0, 0, '0, '0, 1, 1, 32'h600);
    check("t3_mis_tgt", mispredict, 1);
    check("t3_redir_tgt", redirect_pc, 32'h600);
    idle();
    drive(1, 1, 32'h300, 32'h500, 0, 0, '0);
    drive(0, 0, '0, '0, 1, 0, '0);
    check("t3_mis_nt", mispredict, 1);
    check("t3_redir_nt", redirect_pc, 32'h304);
    idle();

    // fill, blocked 5th push, flush with concurrent push
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 0, 32'h1000 + 32'(i * 16), '0, 0, 0, '0);
    check("t4_ready_full", pred_ready, 0);
    check("t4_occ_full", occupancy, 4);
    drive(1, 0, 32'h2000, '0, 1, 1, 32'h700);
    check("t4_occ_flush", occupancy, 0);
    check("t4_ready_mis", pred_ready, 0);
    check("t4_mis", mispredict, 1);
    check("t4_redir", redirect_pc, 32'h700);
    idle();
    check("t4_ready_after", pred_ready, 1);
    check("t4_occ_after", occupancy, 0);

    // underflow
    do_reset();
    drive(0, 0, '0, '0, 1, 1, 32'h40);
    check("t5_uf", underflow_err, 1);
    check("t5_upd", upd_valid, 0);
    check("t5_bc", branch_count, 0);
    idle();
    check("t5_uf_sticky", underflow_err, 1);
    do_reset();
    check("t5_uf_clr", underflow_err, 0);

    // mispredict counter saturation, then reset with entries queued
    for (int i = 0; i < CMAX + 1; i++) begin
      drive(1, 0, 32'h80, '0, 0, 0, '0);
      drive(0, 0, '0, '0, 1, 1, 32'h90);
      idle();
    end
    check("t6_mc_sat", mispredict_count, CMAX);
    check("t6_bc_sat", branch_count, CMAX);
    for (int i = 0; i < 3; i++) drive(1, 1, 32'hA0, 32'hB0, 0, 0, '0);
    check("t6_occ3", occupancy, 3);
    reset = 1;
    drive(0, 0, '0, '0, 1, 1, 32'hB0);
    reset = 0;
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_upd", upd_valid, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 1),
            32'($urandom_range(0, 255)) << 2,
            $urandom_range(0, 1) ? 32'h1000 : 32'h2000,
            $urandom_range(0, 99) < 40, $urandom_range(0, 1),
            $urandom_range(0, 1) ? 32'h1000 : 32'h2000);
    end
    reset = 0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
